// File: rtl/source_sel_gen.sv
// N-channel test-source selector for the FMCA serializer word.
// A debounced button or an external select picks the channel; each change emits a guard run of IDLE_WORD.
module source_sel_gen #(
    parameter int              DW        = 128,
    parameter int              NCH       = 4,
    parameter int              SELW      = $clog2(NCH),
    parameter int              DEB_CYC   = 1600000,
    parameter int              GUARD_CYC = 8,
    parameter logic [DW-1:0]   IDLE_WORD = '0
) (
    input  logic                clk160,
    input  logic                rst_n,
    input  logic [NCH*DW-1:0]   ch_data,
    input  logic                btn_n,
    input  logic                ext_en,
    input  logic [SELW-1:0]     sel_ext,
    output logic [DW-1:0]       dout,
    output logic [SELW-1:0]     indic,
    output logic                busy,
    output logic [7:0]          switch_cnt
);

    localparam int DCW = $clog2(DEB_CYC);
    localparam int GCW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    typedef enum logic {RUN, GUARD} state_t;

    logic            sync1_q, sync2_q;
    logic            deb_q, deb_d;
    logic [DCW-1:0]  deb_cnt_q, deb_cnt_d;
    logic            step;
    logic [SELW-1:0] req_q, req_d;
    logic [SELW-1:0] active_q;
    state_t          state_q;
    logic [GCW-1:0]  gcnt_q;
    logic [DW-1:0]   dout_q;
    logic [SELW-1:0] indic_q;
    logic            busy_q;
    logic [7:0]      switch_cnt_q;
    logic [DW-1:0]   ch_arr [NCH];
    logic [DW-1:0]   active_word, req_word;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
            assign ch_arr[gi] = ch_data[gi*DW +: DW];
        end
    endgenerate

    always_comb begin
        active_word = IDLE_WORD;
        req_word    = IDLE_WORD;
        for (int k = 0; k < NCH; k++) begin
            if (active_q == SELW'(k)) active_word = ch_arr[k];
            if (req_q == SELW'(k))    req_word    = ch_arr[k];
        end
    end

    // Level only follows the synced button after DEB_CYC consecutive disagreeing cycles.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DCW'(DEB_CYC - 1)) begin
                deb_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end
    end

    assign step = deb_q & ~deb_d;

    always_comb begin
        req_d = req_q;
        if (ext_en) begin
            if (int'(sel_ext) < NCH) req_d = sel_ext;
        end else if (step) begin
            req_d = (req_q == SELW'(NCH - 1)) ? '0 : req_q + 1'b1;
        end
    end

    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            deb_q     <= 1'b1;
            deb_cnt_q <= '0;
            req_q     <= '0;
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_cnt_q <= deb_cnt_d;
            req_q     <= req_d;
        end
    end

    // Exit samples req on the last guard cycle, so a mid-guard change just retargets the switch.
    always_ff @(posedge clk160 or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            gcnt_q       <= '0;
            active_q     <= '0;
            dout_q       <= '0;
            indic_q      <= '0;
            busy_q       <= 1'b0;
            switch_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (req_q != active_q) begin
                        state_q <= GUARD;
                        gcnt_q  <= '0;
                        busy_q  <= 1'b1;
                        dout_q  <= IDLE_WORD;
                    end else begin
                        dout_q  <= active_word;
                    end
                end
                GUARD: begin
                    if (gcnt_q == GCW'(GUARD_CYC - 1)) begin
                        state_q      <= RUN;
                        active_q     <= req_q;
                        indic_q      <= req_q;
                        busy_q       <= 1'b0;
                        switch_cnt_q <= switch_cnt_q + 8'd1;
                        dout_q       <= req_word;
                    end else begin
                        gcnt_q <= gcnt_q + 1'b1;
                        dout_q <= IDLE_WORD;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign dout       = dout_q;
    assign indic      = indic_q;
    assign busy       = busy_q;
    assign switch_cnt = switch_cnt_q;

endmodule

// File: tb/tb_source_sel_gen.sv
// Directed bench for source_sel_gen: button stepping, glitch rejection, external select,
// mid-guard retarget, async reset mid-guard and switch counter wrap.
module tb_source_sel_gen;

    localparam int DW   = 128;
    localparam int NCH  = 4;
    localparam int SELW = 3;

    logic                clk160;
    logic                rst_n;
    logic [NCH*DW-1:0]   ch_data;
    logic                btn_n;
    logic                ext_en;
    logic [SELW-1:0]     sel_ext;
    logic [DW-1:0]       dout;
    logic [SELW-1:0]     indic;
    logic                busy;
    logic [7:0]          switch_cnt;

    int checks_total  = 0;
    int checks_passed = 0;

    source_sel_gen #(
        .DW(DW), .NCH(NCH), .SELW(SELW), .DEB_CYC(4), .GUARD_CYC(3), .IDLE_WORD('0)
    ) dut (
        .clk160(clk160), .rst_n(rst_n), .ch_data(ch_data), .btn_n(btn_n),
        .ext_en(ext_en), .sel_ext(sel_ext), .dout(dout), .indic(indic),
        .busy(busy), .switch_cnt(switch_cnt)
    );

    initial clk160 = 1'b0;
    always #5 clk160 = ~clk160;

    function automatic logic [DW-1:0] word(input int k);
        logic [7:0] b;
        b = 8'h10 + 8'(k);
        return {16{b}};
    endfunction

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Waits for a guard to start, checks every guard word, then the post-switch state.
    task automatic observe(input string tag, input int exp_ch, input int exp_cnt, input int mid_sel);
        bit seen;
        int n;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk160);
            if (busy) seen = 1'b1;
        end
        check_val({tag, ":start"}, DW'(seen), DW'(1));
        if (!seen) return;
        if (mid_sel >= 0) sel_ext = SELW'(mid_sel);
        n = 0;
        while (busy && n < 10) begin
            check_val({tag, ":idle"}, dout, '0);
            n++;
            @(negedge clk160);
        end
        check_val({tag, ":guard_len"}, DW'(n), DW'(3));
        check_val({tag, ":dout"}, dout, word(exp_ch));
        check_val({tag, ":indic"}, DW'(indic), DW'(exp_ch));
        check_val({tag, ":cnt"}, DW'(switch_cnt), DW'(exp_cnt));
        $display("switch %s: ch=%0d indic=%0d cnt=%0d guard=%0d", tag, exp_ch, indic, switch_cnt, n);
    endtask

    task automatic press(input string tag, input int exp_ch, input int exp_cnt);
        btn_n = 1'b0;
        fork
            begin
                repeat (10) @(negedge clk160);
                btn_n = 1'b1;
            end
        join_none
        observe(tag, exp_ch, exp_cnt, -1);
        repeat (15) @(negedge clk160);
    endtask

    task automatic expect_quiet(input string tag, input int exp_ch);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk160);
            if (busy) seen = 1'b1;
        end
        check_val({tag, ":no_guard"}, DW'(seen), DW'(0));
        check_val({tag, ":indic"}, DW'(indic), DW'(exp_ch));
        check_val({tag, ":dout"}, dout, word(exp_ch));
        $display("quiet %s: indic=%0d busy_seen=%0d", tag, indic, seen);
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = word(k);
        rst_n   = 1'b0;
        btn_n   = 1'b1;
        ext_en  = 1'b0;
        sel_ext = '0;
        repeat (3) @(negedge clk160);
        check_val("rst:dout", dout, '0);
        check_val("rst:busy", DW'(busy), DW'(0));
        rst_n = 1'b1;
        @(negedge clk160);
        check_val("rel:dout", dout, word(0));
        check_val("rel:indic", DW'(indic), DW'(0));
        check_val("rel:busy", DW'(busy), DW'(0));
        check_val("rel:cnt", DW'(switch_cnt), DW'(0));
        $display("reset released: dout=%h", dout);
        repeat (4) @(negedge clk160);

        press("btn1", 1, 1);

        btn_n = 1'b0;
        repeat (3) @(negedge clk160);
        btn_n = 1'b1;
        expect_quiet("glitch", 1);

        press("btn2", 2, 2);
        press("btn3", 3, 3);
        press("btn4", 0, 4);

        ext_en  = 1'b1;
        sel_ext = 3'd2;
        observe("ext_mid", 3, 5, 3);
        repeat (5) @(negedge clk160);
        sel_ext = 3'd5;
        expect_quiet("ext_oor", 3);

        sel_ext = 3'd1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk160);
                if (busy) seen = 1'b1;
            end
            check_val("rstg:start", DW'(seen), DW'(1));
        end
        @(negedge clk160);
        rst_n = 1'b0;
        #1;
        check_val("rstg:dout", dout, '0);
        check_val("rstg:indic", DW'(indic), DW'(0));
        check_val("rstg:busy", DW'(busy), DW'(0));
        check_val("rstg:cnt", DW'(switch_cnt), DW'(0));
        $display("reset mid-guard: dout=%h indic=%0d busy=%0d", dout, indic, busy);
        ext_en  = 1'b0;
        sel_ext = '0;
        @(negedge clk160);
        rst_n = 1'b1;
        @(negedge clk160);
        check_val("rstg:rel_dout", dout, word(0));
        check_val("rstg:rel_cnt", DW'(switch_cnt), DW'(0));
        expect_quiet("rstg:after", 0);

        ext_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            int ch;
            ch = (i % 2 == 0) ? 1 : 0;
            sel_ext = SELW'(ch);
            observe($sformatf("wrap%0d", i), ch, (i + 1) % 256, -1);
        end
        check_val("wrap:final_cnt", DW'(switch_cnt), DW'(0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
